// File: rtl/commit_trace_buf_pkg.sv
// Shared CPU trace definitions: record field widths, record layout, normalisation.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package commit_trace_buf_pkg;

  localparam int PC_W   = 32;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  // One retired-instruction record as stored in the trace FIFO (sequence number appended separately).
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              ena;
    logic [REG_W-1:0]  rg;
    logic [DATA_W-1:0] value;
  } trc_rec_t;

  localparam int TRC_REC_W = $bits(trc_rec_t);

  // Writes to x0 are architecturally discarded, so they are traced as no-write with a zero value.
  function automatic trc_rec_t trc_normalize(
    input logic [PC_W-1:0]   pc,
    input logic              ena,
    input logic [REG_W-1:0]  rg,
    input logic [DATA_W-1:0] value
  );
    trc_rec_t r;
    r.pc    = pc;
    r.ena   = ena && (rg != '0);
    r.rg    = rg;
    r.value = r.ena ? value : '0;
    return r;
  endfunction

endpackage

// File: rtl/commit_trace_buf_if.sv
// Trace output stream: head record plus valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: consumer holds trc_ready low to stall; producer keeps fields stable.
interface commit_trace_buf_if #(
  parameter int SEQ_W = 16
);
  import commit_trace_buf_pkg::*;

  logic              trc_valid;
  logic              trc_ready;
  logic [PC_W-1:0]   trc_pc;
  logic              trc_ena;
  logic [REG_W-1:0]  trc_reg;
  logic [DATA_W-1:0] trc_value;
  logic [SEQ_W-1:0]  trc_seq;

  modport master (
    output trc_valid, trc_pc, trc_ena, trc_reg, trc_value, trc_seq,
    input  trc_ready
  );

  modport slave (
    input  trc_valid, trc_pc, trc_ena, trc_reg, trc_value, trc_seq,
    output trc_ready
  );

endinterface

// File: rtl/commit_trace_buf_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; read data masked to zero when empty.
// Latency: a push in cycle N is visible on pop_dat from cycle N+1 (no bypass).
// Backpressure: push is refused when full unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              pop_ok;
  logic              push_ok;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (level == (ADDR_W+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign push_ok = push && (!full || pop_ok);
  assign pop_dat = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

  // Pointer advance; the MSB distinguishes full from empty after wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem_q[wr_ptr_q[ADDR_W-1:0]] <= push_dat;
  end

endmodule

// File: rtl/commit_trace_buf.sv
// Commit trace buffer: normalises WB retirements, tags sequence numbers, counts commits/drops.
// Latency: a retirement in cycle N appears on the trace stream from cycle N+1.
// Backpressure: trc_ready low stalls the head; retirements arriving while full are dropped and counted.
module commit_trace_buf
  import commit_trace_buf_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
) (
  input  logic                     clk_cpu,
  input  logic                     rst_cpu,
  input  logic                     wb_have_inst,
  input  logic [PC_W-1:0]          wb_pc,
  input  logic                     wb_ena,
  input  logic [REG_W-1:0]         wb_reg,
  input  logic [DATA_W-1:0]        wb_value,
  input  logic                     trc_clear,
  commit_trace_buf_if.master       trc,
  output logic [31:0]              commit_cnt,
  output logic [15:0]              drop_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int FIFO_W = TRC_REC_W + SEQ_W;

  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [31:0]       commit_cnt_q, commit_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;

  trc_rec_t          rec_in;
  trc_rec_t          head_rec;
  logic [SEQ_W-1:0]  seq_in;
  logic [FIFO_W-1:0] push_dat;
  logic [FIFO_W-1:0] pop_dat;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              drop;

  assign rec_in   = trc_normalize(wb_pc, wb_ena, wb_reg, wb_value);
  // A clear in the same cycle restarts numbering at this very record.
  assign seq_in   = trc_clear ? '0 : seq_q;
  assign push_dat = {rec_in, seq_in};
  assign pop      = trc.trc_valid && trc.trc_ready;
  assign drop     = wb_have_inst && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk_cpu),
    .rst      (rst_cpu),
    .push     (wb_have_inst),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  assign head_rec      = pop_dat[FIFO_W-1:SEQ_W];
  assign trc.trc_valid = !fifo_empty;
  assign trc.trc_pc    = head_rec.pc;
  assign trc.trc_ena   = head_rec.ena;
  assign trc.trc_reg   = head_rec.rg;
  assign trc.trc_value = head_rec.value;
  assign trc.trc_seq   = pop_dat[SEQ_W-1:0];

  // Counter/flag next state: clear overrides any retirement in the same cycle.
  always_comb begin
    seq_d        = seq_q;
    commit_cnt_d = commit_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    overflow_d   = overflow_q;
    if (trc_clear) begin
      seq_d        = '0;
      commit_cnt_d = '0;
      drop_cnt_d   = '0;
      overflow_d   = 1'b0;
    end else if (wb_have_inst) begin
      seq_d        = seq_q + SEQ_W'(1);
      commit_cnt_d = commit_cnt_q + 32'd1;
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  // Counter/flag registers with synchronous reset.
  always_ff @(posedge clk_cpu) begin
    if (rst_cpu) begin
      seq_q        <= '0;
      commit_cnt_q <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      seq_q        <= seq_d;
      commit_cnt_q <= commit_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign commit_cnt = commit_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/commit_trace_buf.md
COMMIT_TRACE_BUF -- requirements
Module: commit_trace_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count, power of two, 2..256.
REQ-002 SHALL have parameter SEQ_W, default 16, width of the per-commit sequence number.
REQ-003 SHALL have port clk_cpu, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_cpu, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port wb_have_inst, input, 1, a WB-stage instruction retires this cycle.
REQ-006 SHALL have port wb_pc, input, 32, PC of the retiring instruction.
REQ-007 SHALL have port wb_ena, input, 1, register-write enable of the retiring instruction.
REQ-008 SHALL have port wb_reg, input, 5, destination register number.
REQ-009 SHALL have port wb_value, input, 32, value written to the destination register.
REQ-010 SHALL have port trc_clear, input, 1, synchronous clear of counters and sticky flag.
REQ-011 SHALL have port trc_ready, input, 1, downstream consumer accepts the head record.
REQ-012 SHALL have port trc_valid, output, 1, head record present.
REQ-013 SHALL have ports trc_pc (32), trc_ena (1), trc_reg (5), trc_value (32) and trc_seq (SEQ_W), all outputs, carrying the head record fields.
REQ-014 SHALL have port commit_cnt, output, 32, total retirements seen.
REQ-015 SHALL have port drop_cnt, output, 16, retirements lost to a full FIFO.
REQ-016 SHALL have port overflow, output, 1, sticky flag, set on the first drop.
REQ-017 SHALL have port level, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-018 SHALL push one record in any cycle with wb_have_inst=1 and FIFO not full (after that cycle's pop).
REQ-019 SHALL store ena as wb_ena AND (wb_reg != 0); when the stored ena is 0, SHALL store value as 0.
REQ-020 SHALL assign trc_seq from a SEQ_W-bit counter that increments on every retirement, pushed or dropped, and wraps modulo 2^SEQ_W.
REQ-021 SHALL pop the head when trc_valid=1 and trc_ready=1 in the same cycle.
REQ-022 SHALL use a registered, non-bypass data path: a record pushed in cycle N appears on trc_* no earlier than cycle N+1.
REQ-023 SHALL keep trc_* stable while trc_valid=1 and trc_ready=0.
REQ-024 SHALL accept a push when full if a pop occurs in the same cycle; level stays DEPTH.
REQ-025 SHALL, on a push and pop while empty, pop nothing; level becomes 1.
REQ-026 SHALL, on a retirement while full with no pop, drop the record, increment drop_cnt (saturating at 16'hFFFF), and set overflow.
REQ-027 SHALL increment commit_cnt on every retirement, wrapping at 2^32.
REQ-028 SHALL wrap read and write pointers modulo DEPTH, using an extra MSB for full/empty detection.
REQ-029 SHALL give trc_clear the following effect: zero commit_cnt, drop_cnt, overflow and the sequence counter, with no effect on FIFO contents; if a retirement occurs in the same cycle, clear wins for the counters while the record still pushes with seq 0.
REQ-030 SHALL ignore wb_pc, wb_ena, wb_reg and wb_value when wb_have_inst=0.

Reset
REQ-031 SHALL, while rst_cpu=1 at a clock edge, empty the FIFO, set trc_valid=0 and level=0, and zero all counters and overflow; trc_* data outputs SHALL be 0.
REQ-032 SHALL, when reset is asserted mid-operation, discard all buffered records with no pop reported; wb_have_inst in that same cycle SHALL be ignored.

Structure
REQ-033 SHALL place the record field widths (PC_W=32, REG_W=5, DATA_W=32) and the trace record struct/packing constant in the shared CPU package.
REQ-034 SHALL instantiate one sub-module, sync_fifo (parameterised width/depth, synchronous reset), for storage; normalisation, counters and flags SHALL live in commit_trace_buf.

Verification
REQ-035 SHALL cover single retirement: pc=0x0000_0004, ena=1, reg=5, value=0x1234 at cycle N, with trc_ready=1 -> trc_valid at N+1 with identical fields, seq=0, and commit_cnt=1.
REQ-036 SHALL cover x0 write: ena=1, reg=0, value=0xDEAD -> record shows ena=0 and value=0.
REQ-037 SHALL cover overflow: DEPTH=16, trc_ready=0, 20 retirements -> level=16, drop_cnt=4, overflow=1, and the head seq is 0; after draining, seqs read are 0..15.
REQ-038 SHALL cover full plus simultaneous push/pop: full, trc_ready=1, one retirement -> no drop, level stays 16, and the new record eventually appears with seq 16.
REQ-039 SHALL cover backpressure: trc_ready toggles 0/1 every cycle over 8 retirements -> all 8 records are delivered in order with no field changes while stalled.
REQ-040 SHALL cover reset mid-stream: 5 records buffered, then rst_cpu=1 for one cycle together with a retirement -> level=0, trc_valid=0, and commit_cnt=0 afterwards.
